// File: rtl/mc_pkg.sv
// Shared microsequencer definitions: state encodings, opcode constants, widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_pkg;

    localparam int STATE_W  = 4;
    localparam int OPCODE_W = 6;
    localparam int ICNT_W   = 16;
    localparam int ECNT_W   = 8;

    localparam logic [ECNT_W-1:0] ECNT_MAX = '1;

    // Microstate encodings; the microprogram ROM is addressed by these values.
    // Codes 10..15 are unused and treated as invalid states.
    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        JEX     = 4'd9
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    // Dispatch table select: table 1 is used in DECODE, table 2 in MEMADR.
    localparam logic TBL_DECODE = 1'b0;
    localparam logic TBL_MEMADR = 1'b1;

    // States whose exit to FETCH completes (retires) an instruction.
    function automatic logic is_retire_src(input state_t s);
        return s inside {MEMWB, MEMWR, RTYPEWB, BEQEX, JEX};
    endfunction

endpackage

// File: rtl/dispatch_rom.sv
// Opcode dispatch tables for DECODE (table 1) and MEMADR (table 2).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is used.
module dispatch_rom
    import mc_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_tbl_sel,
    output state_t              o_next_state,
    output logic                o_illegal
);

    // Table lookup; any opcode without an entry falls back to FETCH and is flagged illegal.
    always_comb begin
        o_next_state = FETCH;
        o_illegal    = 1'b1;
        if (i_tbl_sel == TBL_DECODE) begin
            case (i_opcode)
                OP_RTYPE: begin o_next_state = RTYPEEX; o_illegal = 1'b0; end
                OP_LW:    begin o_next_state = MEMADR;  o_illegal = 1'b0; end
                OP_SW:    begin o_next_state = MEMADR;  o_illegal = 1'b0; end
                OP_BEQ:   begin o_next_state = BEQEX;   o_illegal = 1'b0; end
                OP_J:     begin o_next_state = JEX;     o_illegal = 1'b0; end
                default:  ;
            endcase
        end else begin
            case (i_opcode)
                OP_LW:    begin o_next_state = MEMRD;   o_illegal = 1'b0; end
                OP_SW:    begin o_next_state = MEMWR;   o_illegal = 1'b0; end
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: increment/dispatch/return control plus retire and error counters.
// Latency: state, illegal_op and counters are registered, one cycle after the deciding inputs.
// Backpressure: stall=1 freezes state and counters for that cycle and forces illegal_op low.
module microsequencer
    import mc_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                addrctl,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                stall,
    output logic [STATE_W-1:0]  state,
    output logic                illegal_op,
    output logic [ICNT_W-1:0]   instr_count,
    output logic [ECNT_W-1:0]   err_count
);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_illegal;
    logic                w_retire;
    logic                w_tbl_sel;
    state_t              w_disp_state;
    logic                w_disp_illegal;
    logic                r_illegal_op;
    logic [ICNT_W-1:0]   r_instr_count;
    logic [ECNT_W-1:0]   r_err_count;

    assign w_tbl_sel = (r_state == MEMADR) ? TBL_MEMADR : TBL_DECODE;

    dispatch_rom u_dispatch (
        .i_opcode     (opcode),
        .i_tbl_sel    (w_tbl_sel),
        .o_next_state (w_disp_state),
        .o_illegal    (w_disp_illegal)
    );

    // State register; stall simply withholds the update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
        end else if (!stall) begin
            r_state <= w_next_state;
        end
    end

    // Next-state, fault and retire decode from the current state, addrctl and opcode only.
    always_comb begin
        w_next_state = FETCH;
        w_illegal    = 1'b0;
        if (r_state > JEX) begin
            // Unused encodings recover to FETCH no matter what addrctl says.
            w_illegal = 1'b1;
        end else if (addrctl) begin
            // JEX is the last encoding; incrementing past it would land in an invalid state.
            if (r_state != JEX) begin
                w_next_state = state_t'(r_state + 4'd1);
            end
        end else if ((r_state == DECODE) || (r_state == MEMADR)) begin
            w_next_state = w_disp_state;
            w_illegal    = w_disp_illegal;
        end
        w_retire = (w_next_state == FETCH) && !w_illegal && is_retire_src(r_state);
    end

    // Fault pulse and counters; the pulse lands together with the FETCH it caused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_illegal_op  <= 1'b0;
            r_instr_count <= '0;
            r_err_count   <= '0;
        end else if (stall) begin
            r_illegal_op  <= 1'b0;
        end else begin
            r_illegal_op <= w_illegal;
            if (w_retire) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
            if (w_illegal && (r_err_count != ECNT_MAX)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign state       = r_state;
    assign illegal_op  = r_illegal_op;
    assign instr_count = r_instr_count;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_microsequencer.sv
module tb_microsequencer;
    import mc_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        addrctl;
    logic [5:0]  opcode;
    logic        stall;
    logic [3:0]  state;
    logic        illegal_op;
    logic [15:0] instr_count;
    logic [7:0]  err_count;

    int checks;
    int failures;
    bit ill_seen;

    microsequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addrctl     (addrctl),
        .opcode      (opcode),
        .stall       (stall),
        .state       (state),
        .illegal_op  (illegal_op),
        .instr_count (instr_count),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // State numbers follow the published encoding; dispatch is a map lookup.
    int disp1[int];
    int disp2[int];
    int m_state;
    int m_icnt;
    int m_ecnt;
    bit m_ill;

    function automatic void model_reset();
        m_state = 0; m_icnt = 0; m_ecnt = 0; m_ill = 1'b0;
    endfunction

    function automatic void model_edge(input bit a, input int op, input bit st);
        int nxt;
        bit ill;
        if (st) begin
            m_ill = 1'b0;
            return;
        end
        ill = 1'b0;
        nxt = 0;
        if (m_state >= 10) ill = 1'b1;
        else if (a) nxt = (m_state == 9) ? 0 : m_state + 1;
        else if (m_state == 1) begin
            if (disp1.exists(op)) nxt = disp1[op]; else ill = 1'b1;
        end else if (m_state == 2) begin
            if (disp2.exists(op)) nxt = disp2[op]; else ill = 1'b1;
        end
        if (nxt == 0 && !ill && (m_state inside {4, 5, 7, 8, 9}))
            m_icnt = (m_icnt + 1) % 65536;
        if (ill && m_ecnt < 255) m_ecnt = m_ecnt + 1;
        m_ill   = ill;
        m_state = nxt;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called just after a falling edge: drive, let one rising edge pass, return at the next falling edge.
    task automatic cyc(input bit a, input logic [5:0] op, input bit st);
        addrctl = a;
        opcode  = op;
        stall   = st;
        @(negedge clk);
        if (illegal_op === 1'b1) ill_seen = 1'b1;
    endtask

    task automatic stepchk(input string name, input bit a, input logic [5:0] op, input int exp_state);
        cyc(a, op, 1'b0);
        chk(name, state, exp_state);
    endtask

    task automatic do_reset();
        addrctl = 1'b0; opcode = '0; stall = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ill_seen = 1'b0;
    endtask

    typedef struct {
        bit         sel;
        logic [5:0] op;
        int         exp_state;
        bit         exp_ill;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; ill_seen = 1'b0;
        disp1[0] = 6; disp1[35] = 2; disp1[43] = 2; disp1[4] = 8; disp1[2] = 9;
        disp2[35] = 3; disp2[43] = 5;

        vecs[0]  = '{0, 6'b000000, 6, 0};
        vecs[1]  = '{0, 6'b100011, 2, 0};
        vecs[2]  = '{0, 6'b101011, 2, 0};
        vecs[3]  = '{0, 6'b000100, 8, 0};
        vecs[4]  = '{0, 6'b000010, 9, 0};
        vecs[5]  = '{0, 6'b111111, 0, 1};
        vecs[6]  = '{0, 6'b000001, 0, 1};
        vecs[7]  = '{1, 6'b100011, 3, 0};
        vecs[8]  = '{1, 6'b101011, 5, 0};
        vecs[9]  = '{1, 6'b000000, 0, 1};
        vecs[10] = '{1, 6'b000100, 0, 1};

        // Reset values
        reset_n = 1'b0; addrctl = 1'b0; opcode = '0; stall = 1'b0;
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_icnt", instr_count, 0);
        chk("rst_ecnt", err_count, 0);
        reset_n = 1'b1;

        // Dispatch tables
        for (int i = 0; i < 11; i++) begin
            do_reset();
            cyc(1'b1, vecs[i].op, 1'b0);
            if (vecs[i].sel) cyc(1'b1, vecs[i].op, 1'b0);
            cyc(1'b0, vecs[i].op, 1'b0);
            chk($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            chk($sformatf("vec%0d_illegal", i), illegal_op, vecs[i].exp_ill);
            chk($sformatf("vec%0d_ecnt", i), err_count, vecs[i].exp_ill);
        end

        // lw full path
        do_reset();
        stepchk("lw_s1", 1, OP_LW, 1);
        stepchk("lw_s2", 0, OP_LW, 2);
        stepchk("lw_s3", 0, OP_LW, 3);
        stepchk("lw_s4", 1, OP_LW, 4);
        stepchk("lw_s0", 0, OP_LW, 0);
        chk("lw_icnt", instr_count, 1);

        // sw then R-type back to back
        do_reset();
        stepchk("sw_s1", 1, OP_SW, 1);
        stepchk("sw_s2", 0, OP_SW, 2);
        stepchk("sw_s5", 0, OP_SW, 5);
        stepchk("sw_s0", 0, OP_SW, 0);
        stepchk("r_s1", 1, OP_RTYPE, 1);
        stepchk("r_s6", 0, OP_RTYPE, 6);
        stepchk("r_s7", 1, OP_RTYPE, 7);
        stepchk("r_s0", 0, OP_RTYPE, 0);
        chk("swr_icnt", instr_count, 2);
        chk("swr_no_illegal", ill_seen, 0);

        // Illegal opcode in DECODE
        do_reset();
        stepchk("bad_s1", 1, 6'b111111, 1);
        stepchk("bad_s0", 0, 6'b111111, 0);
        chk("bad_illegal", illegal_op, 1);
        chk("bad_ecnt", err_count, 1);
        chk("bad_icnt", instr_count, 0);
        stepchk("bad_next_s1", 1, 6'b111111, 1);
        chk("bad_pulse_end", illegal_op, 0);

        // Stall in MEMRD
        do_reset();
        stepchk("st_s1", 1, OP_LW, 1);
        stepchk("st_s2", 0, OP_LW, 2);
        stepchk("st_s3", 0, OP_LW, 3);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, OP_LW, 1'b1);
            chk($sformatf("st_hold%0d", k), state, 3);
            chk($sformatf("st_icnt%0d", k), instr_count, 0);
        end
        stepchk("st_s4", 1, OP_LW, 4);
        chk("st_icnt_mwb", instr_count, 0);
        stepchk("st_s0", 0, OP_LW, 0);
        chk("st_icnt_done", instr_count, 1);

        // Stall masks a pending fault, which then fires once stall drops
        do_reset();
        stepchk("sf_s1", 1, 6'b111111, 1);
        cyc(1'b0, 6'b111111, 1'b1);
        chk("sf_hold_state", state, 1);
        chk("sf_hold_illegal", illegal_op, 0);
        chk("sf_hold_ecnt", err_count, 0);
        stepchk("sf_s0", 0, 6'b111111, 0);
        chk("sf_illegal", illegal_op, 1);
        chk("sf_ecnt", err_count, 1);

        // addrctl=1 in JEX returns to FETCH and retires
        do_reset();
        stepchk("jx_s1", 1, OP_J, 1);
        stepchk("jx_s9", 0, OP_J, 9);
        stepchk("jx_s0", 1, OP_J, 0);
        chk("jx_illegal", illegal_op, 0);
        chk("jx_icnt", instr_count, 1);

        // Invalid state recovery
        do_reset();
        force dut.r_state = state_t'(4'd12);
        #1;
        release dut.r_state;
        chk("inv_state_loaded", state, 12);
        stepchk("inv_s0", 1, OP_LW, 0);
        chk("inv_illegal", illegal_op, 1);
        chk("inv_ecnt", err_count, 1);
        chk("inv_icnt", instr_count, 0);

        // Asynchronous reset in RTYPEEX after five retirements
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, OP_J, 1'b0);
            cyc(1'b0, OP_J, 1'b0);
            cyc(1'b0, OP_J, 1'b0);
        end
        chk("ar_icnt5", instr_count, 5);
        stepchk("ar_s1", 1, OP_RTYPE, 1);
        stepchk("ar_s6", 0, OP_RTYPE, 6);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_state", state, 0);
        chk("ar_icnt", instr_count, 0);
        #1 reset_n = 1'b1;
        addrctl = 1'b1; opcode = OP_RTYPE; stall = 1'b0;
        @(negedge clk);
        chk("ar_first_edge", state, 1);

        // Error saturation and retire-count wrap
        do_reset();
        for (int k = 0; k < 256; k++) begin
            cyc(1'b1, 6'b111111, 1'b0);
            cyc(1'b0, 6'b111111, 1'b0);
        end
        chk("sat_ecnt", err_count, 255);
        chk("sat_illegal", illegal_op, 1);
        force dut.r_instr_count = 16'hFFFF;
        #1;
        release dut.r_instr_count;
        chk("wrap_preload", instr_count, 16'hFFFF);
        stepchk("wrap_s1", 1, OP_BEQ, 1);
        stepchk("wrap_s8", 0, OP_BEQ, 8);
        stepchk("wrap_s0", 0, OP_BEQ, 0);
        chk("wrap_icnt", instr_count, 0);
        chk("wrap_ecnt", err_count, 255);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            bit         a;
            bit         st;
            logic [5:0] op;
            logic [5:0] pool [5];
            pool[0] = OP_RTYPE; pool[1] = OP_LW; pool[2] = OP_SW; pool[3] = OP_BEQ; pool[4] = OP_J;
            a  = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else                           op = pool[$urandom_range(0, 4)];
            cyc(a, op, st);
            model_edge(a, int'(op), st);
            chk($sformatf("rnd%0d_state", n), state, m_state);
            chk($sformatf("rnd%0d_illegal", n), illegal_op, m_ill);
            chk($sformatf("rnd%0d_icnt", n), instr_count, m_icnt);
            chk($sformatf("rnd%0d_ecnt", n), err_count, m_ecnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 clk  input  1  single rising-edge system clock; the block SHALL use no other clock.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 addrctl  input  1  sequencing control from the current microinstruction: 1 = increment, 0 = branch, dispatch or return.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register, valid from the cycle after FETCH onward.
REQ-005 stall  input  1  memory-wait hold; 1 freezes sequencing for that cycle.
REQ-006 state  output  4  current microstate; the microprogram ROM consumes it as its address.
REQ-007 illegal_op  output  1  one-cycle pulse flagging an unsupported opcode or an invalid state.
REQ-008 instr_count  output  16  count of retired instructions; wraps modulo 2^16.
REQ-009 err_count  output  8  count of illegal_op pulses; saturates at 255.

Function
REQ-010 state SHALL be a registered output; next_state SHALL be combinational from state, addrctl and opcode.
REQ-011 State encodings (4-bit):
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4
- MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, JEX=9
REQ-012 addrctl=1 SHALL give next_state = state+1.
REQ-013 addrctl=0 in DECODE SHALL select next_state from dispatch table 1:
- 000000 -> RTYPEEX
- 100011 -> MEMADR
- 101011 -> MEMADR
- 000100 -> BEQEX
- 000010 -> JEX
- any other opcode -> FETCH, with illegal_op asserted
REQ-014 addrctl=0 in MEMADR SHALL select next_state from dispatch table 2:
- 100011 -> MEMRD
- 101011 -> MEMWR
- any other opcode -> FETCH, with illegal_op asserted
REQ-015 addrctl=0 in any other valid state SHALL give next_state = FETCH.
REQ-016 If state holds 10..15, next_state SHALL be FETCH and illegal_op SHALL assert, regardless of addrctl.
REQ-017 If addrctl=1 in JEX, next_state SHALL be FETCH, not 10.
REQ-018 When stall=1: state, both counters and illegal_op SHALL hold, with illegal_op forced to 0; sequencing resumes on the first cycle with stall=0.
REQ-019 illegal_op SHALL be registered, asserted in the cycle where state==FETCH following the faulting transition, and last exactly one cycle.
REQ-020 instr_count SHALL increment by 1 on each non-stalled transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX or JEX; an illegal return to FETCH SHALL NOT count.
REQ-021 err_count SHALL increment together with each illegal_op assertion and SHALL hold at 255.
REQ-022 The block SHALL introduce no combinational path from its inputs to state.

Reset
REQ-023 Assertion of reset_n=0 SHALL immediately set: state=FETCH, illegal_op=0, instr_count=0, err_count=0.
REQ-024 Reset mid-instruction SHALL abandon the instruction without counting it.
REQ-025 The first sequencing edge SHALL be the first rising clk after reset_n deasserts.

Structure
REQ-026 The following SHALL live in shared package mc_pkg, also used by the microprogram ROM:
- state encodings
- opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J)
- widths
REQ-027 Both dispatch tables SHALL be implemented in one combinational sub-module, dispatch_rom (inputs opcode and table select; outputs next state and an illegal flag).

Verification
REQ-028 lw (opcode 100011), addrctl stream 1,0,0,1,0, no stall -> states 0,1,2,3,4,0; instr_count 0->1.
REQ-029 sw (101011) then R-type (000000) back to back -> states 0,1,2,5,0,1,6,7,0; instr_count=2; illegal_op never asserts.
REQ-030 Opcode 111111 in DECODE with addrctl=0 -> next state 0; illegal_op pulses for exactly 1 cycle; err_count=1; instr_count unchanged.
REQ-031 stall=1 for 3 cycles while state=MEMRD -> state stays 3 for those cycles, then goes to 4; instr_count is unaffected until the return to FETCH.
REQ-032 reset_n pulsed low asynchronously (between clock edges) in RTYPEEX with instr_count=5 -> state=0 and instr_count=0 without waiting for clk.
REQ-033 Force 256 illegal opcodes, then preload instr_count to 0xFFFF and retire one beq -> err_count=255; instr_count=0x0000.
